uart_tx_arbiter: RTL and testbench

Round-robin controller that shares the single UART transmitter between NUM_REQ byte producers. It selects one pending requester, latches that requester's byte and parity configuration, and launches a frame with a one-cycle Data_Valid pulse. It then holds the UART's byte and parity inputs stable until Busy falls and acknowledges the requester. It sits directly in front of the UART top: its outputs drive A0..A7, Data_Valid, Parity_Enable and Parity_Type, and its tx_busy input is the UART Busy output.

---
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------
// Round-robin front end that shares one UART transmitter between NUM_REQ
// byte producers. It picks a pending requester, latches its byte and
// parity settings, fires a one-cycle Data_Valid pulse, and then holds the
// UART inputs steady until Busy falls. The requester is acknowledged once
// the UART has accepted the frame.
//
// Ports
//   CLK            rising-edge clock
//   RST            asynchronous active-low reset
//   req_valid      per-requester "byte pending" flags
//   req_data       per-requester bytes, requester i at [8i+7:8i]
//   req_par_en     per-requester parity enable
//   req_par_type   per-requester parity type
//   req_ready      one-cycle acceptance pulse for the granted requester
//   tx_data        byte to UART A7..A0
//   tx_data_valid  UART Data_Valid (one-cycle launch pulse)
//   tx_par_en      UART Parity_Enable
//   tx_par_type    UART Parity_Type
//   tx_busy        UART Busy
//   grant_id       current or most recent winner
//   active         high while a frame is being launched or carried
//   tx_err         one-cycle pulse when the UART never raised Busy
//
// All outputs are registers. The next-state logic computes their next
// values so that nothing on an input reaches an output combinationally.

module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_par_en,
    input  logic [NUM_REQ-1:0]   req_par_type,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    output logic                 tx_par_en,
    output logic                 tx_par_type,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 active,
    output logic                 tx_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [2:0]           rr_ptr, rr_ptr_n;
    logic [3:0]           cnt, cnt_n;
    logic [7:0]           tx_data_n;
    logic                 tx_par_en_n, tx_par_type_n;
    logic [2:0]           grant_id_n;
    logic [NUM_REQ-1:0]   req_ready_n;
    logic                 tx_err_n;

    logic                 found;
    logic [2:0]           win_id;
    logic [7:0]           win_data;
    logic                 win_pen, win_ptype;

    // Round-robin search. Scanning j over two laps of the requester list
    // and accepting only rr_ptr < j <= rr_ptr+NUM_REQ visits every
    // requester exactly once, starting just after the last winner. Keeping
    // j a loop constant keeps every vector index static.
    always_comb begin
        found     = 1'b0;
        win_id    = 3'd0;
        win_data  = 8'h00;
        win_pen   = 1'b0;
        win_ptype = 1'b0;
        for (int j = 0; j < 2 * NUM_REQ; j++) begin
            if (!found && req_valid[j % NUM_REQ] &&
                (j > int'(rr_ptr)) && (j <= int'(rr_ptr) + NUM_REQ)) begin
                found     = 1'b1;
                win_id    = 3'(j % NUM_REQ);
                win_data  = req_data[(j % NUM_REQ) * 8 +: 8];
                win_pen   = req_par_en[j % NUM_REQ];
                win_ptype = req_par_type[j % NUM_REQ];
            end
        end
    end

    // Next-state and next-output logic. The UART byte and parity registers
    // only move on the IDLE to LAUNCH step, because the UART computes
    // parity combinationally from them for the whole frame.
    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        cnt_n         = cnt;
        tx_data_n     = tx_data;
        tx_par_en_n   = tx_par_en;
        tx_par_type_n = tx_par_type;
        grant_id_n    = grant_id;
        req_ready_n   = '0;
        tx_err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    tx_data_n     = win_data;
                    tx_par_en_n   = win_pen;
                    tx_par_type_n = win_ptype;
                    grant_id_n    = win_id;
                    state_n       = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_n   = 4'd0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_id == 3'(i)) begin
                            req_ready_n[i] = 1'b1;
                        end
                    end
                    rr_ptr_n = grant_id;
                    state_n  = HOLD;
                end else if (cnt + 4'd1 == 4'(START_TIMEOUT)) begin
                    // Abandon the launch without moving rr_ptr so the
                    // same requester is retried first.
                    tx_err_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (!tx_busy) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            rr_ptr        <= 3'(NUM_REQ - 1);
            cnt           <= 4'd0;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            tx_par_en     <= 1'b0;
            tx_par_type   <= 1'b0;
            grant_id      <= 3'd0;
            req_ready     <= '0;
            active        <= 1'b0;
            tx_err        <= 1'b0;
        end else begin
            state         <= state_n;
            rr_ptr        <= rr_ptr_n;
            cnt           <= cnt_n;
            tx_data       <= tx_data_n;
            tx_data_valid <= (state_n == LAUNCH);
            tx_par_en     <= tx_par_en_n;
            tx_par_type   <= tx_par_type_n;
            grant_id      <= grant_id_n;
            req_ready     <= req_ready_n;
            active        <= (state_n != IDLE);
            tx_err        <= tx_err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// ------------------
// Directed bench for uart_tx_arbiter with NUM_REQ=4, START_TIMEOUT=4.
// The bench plays the UART itself by driving tx_busy. Inputs change on the
// falling edge and outputs are sampled on the falling edge.

module tb_uart_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_par_en = '0;
    logic [3:0]  req_par_type = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_par_en;
    logic        tx_par_type;
    logic        tx_busy = 1'b0;
    logic [2:0]  grant_id;
    logic        active;
    logic        tx_err;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_data(req_data),
        .req_par_en(req_par_en), .req_par_type(req_par_type),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_par_en(tx_par_en), .tx_par_type(tx_par_type),
        .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .tx_err(tx_err)
    );

    always #5 CLK = ~CLK;

    // One comparison: count it, and on mismatch count and report it.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Wait (bounded) for the launch cycle.
    task automatic wait_launch(input string tag);
        for (int i = 0; i < 12 && tx_data_valid !== 1'b1; i++) @(negedge CLK);
        check_output(tag, 32'(tx_data_valid), 32'd1);
    endtask

    // Act as the UART for one frame: check the launch, raise Busy, check
    // the single acknowledge, keep Busy up a while, then drop it.
    task automatic apply_stimulus(input string tag, input logic [2:0] id,
                                  input logic [7:0] byte_v, input logic pen,
                                  input logic ptype, input logic [3:0] rdy);
        wait_launch({tag, "_launch"});
        check_output({tag, "_grant"}, 32'(grant_id), 32'(id));
        check_output({tag, "_data"},  32'(tx_data),  32'(byte_v));
        check_output({tag, "_pen"},   32'(tx_par_en), 32'(pen));
        check_output({tag, "_ptype"}, 32'(tx_par_type), 32'(ptype));
        tx_busy = 1'b1;
        step(1);
        check_output({tag, "_valid_drop"}, 32'(tx_data_valid), 32'd0);
        check_output({tag, "_no_early_rdy"}, 32'(req_ready), 32'd0);
        step(1);
        check_output({tag, "_ready"}, 32'(req_ready), 32'(rdy));
        step(2);
        check_output({tag, "_ready_once"}, 32'(req_ready), 32'd0);
        check_output({tag, "_data_hold"}, 32'(tx_data), 32'(byte_v));
        tx_busy = 1'b0;
        step(1);
    endtask

    initial begin
        // Reset state
        step(2);
        check_output("rst_data",   32'(tx_data), 32'h00);
        check_output("rst_valid",  32'(tx_data_valid), 32'd0);
        check_output("rst_ready",  32'(req_ready), 32'd0);
        check_output("rst_grant",  32'(grant_id), 32'd0);
        check_output("rst_active", 32'(active), 32'd0);
        check_output("rst_err",    32'(tx_err), 32'd0);
        RST = 1'b1;
        step(1);

        // Single request on requester 2, even parity
        req_data     = 32'h00A5_0000;
        req_par_en   = 4'b0100;
        req_par_type = 4'b0000;
        req_valid    = 4'b0100;
        apply_stimulus("single", 3'd2, 8'hA5, 1'b1, 1'b0, 4'b0100);
        req_valid = 4'b0000;
        step(1);
        check_output("single_idle", 32'(active), 32'd0);

        // Contention: rr_ptr is now 2, so the rotation starts at 3
        req_data     = 32'h1312_1110;
        req_par_en   = 4'b0101;
        req_par_type = 4'b0011;
        req_valid    = 4'b1111;
        apply_stimulus("rr_a", 3'd3, 8'h13, 1'b0, 1'b0, 4'b1000);
        apply_stimulus("rr_b", 3'd0, 8'h10, 1'b1, 1'b1, 4'b0001);
        apply_stimulus("rr_c", 3'd1, 8'h11, 1'b0, 1'b1, 4'b0010);
        apply_stimulus("rr_d", 3'd2, 8'h12, 1'b1, 1'b0, 4'b0100);
        apply_stimulus("rr_e", 3'd3, 8'h13, 1'b0, 1'b0, 4'b1000);
        apply_stimulus("rr_f", 3'd0, 8'h10, 1'b1, 1'b1, 4'b0001);
        req_valid = 4'b0000;

        // Timeout: four WAIT_BUSY cycles, then tx_err in the first IDLE
        // cycle and a relaunch of requester 1 right after it
        req_data     = 32'h0000_5A00;
        req_par_en   = 4'b0000;
        req_par_type = 4'b0000;
        req_valid    = 4'b0010;
        wait_launch("to_launch");
        check_output("to_grant", 32'(grant_id), 32'd1);
        step(4);
        check_output("to_no_err_yet", 32'(tx_err), 32'd0);
        check_output("to_still_active", 32'(active), 32'd1);
        step(1);
        check_output("to_err", 32'(tx_err), 32'd1);
        check_output("to_idle", 32'(active), 32'd0);
        check_output("to_no_ready", 32'(req_ready), 32'd0);
        step(1);
        check_output("to_relaunch", 32'(tx_data_valid), 32'd1);
        check_output("to_regrant", 32'(grant_id), 32'd1);
        check_output("to_err_once", 32'(tx_err), 32'd0);
        req_valid = 4'b0000;
        tx_busy   = 1'b1;
        step(2);
        check_output("to_ready", 32'(req_ready), 32'b0010);
        tx_busy = 1'b0;
        step(2);

        // Busy at idle: nothing launches until Busy drops
        tx_busy   = 1'b1;
        req_data  = 32'h0000_0077;
        req_valid = 4'b0001;
        step(3);
        check_output("bi_no_launch", 32'(tx_data_valid), 32'd0);
        check_output("bi_inactive", 32'(active), 32'd0);
        tx_busy = 1'b0;
        step(1);
        check_output("bi_launch", 32'(tx_data_valid), 32'd1);
        check_output("bi_grant", 32'(grant_id), 32'd0);
        check_output("bi_data", 32'(tx_data), 32'h77);
        tx_busy = 1'b1;
        step(2);
        check_output("bi_ready", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        tx_busy   = 1'b0;
        step(2);

        // Withdrawal: requester 3 drops req_valid during LAUNCH
        req_data  = 32'hC300_0000;
        req_valid = 4'b1000;
        wait_launch("wd_launch");
        check_output("wd_grant", 32'(grant_id), 32'd3);
        req_valid = 4'b0000;
        tx_busy   = 1'b1;
        step(2);
        check_output("wd_ready", 32'(req_ready), 32'b1000);
        check_output("wd_data", 32'(tx_data), 32'hC3);
        step(1);
        check_output("wd_ready_once", 32'(req_ready), 32'd0);
        tx_busy = 1'b0;
        step(2);

        // Reset mid-HOLD: requester 1 wins, then reset during Busy
        req_data  = 32'h0000_6600;
        req_valid = 4'b0110;
        wait_launch("rh_launch");
        check_output("rh_grant", 32'(grant_id), 32'd1);
        tx_busy = 1'b1;
        step(3);
        check_output("rh_in_hold", 32'(active), 32'd1);
        RST = 1'b0;
        #1;
        check_output("rh_rst_active", 32'(active), 32'd0);
        check_output("rh_rst_data", 32'(tx_data), 32'h00);
        check_output("rh_rst_grant", 32'(grant_id), 32'd0);
        check_output("rh_rst_ready", 32'(req_ready), 32'd0);
        step(2);
        tx_busy      = 1'b0;
        req_data     = 32'h1312_1110;
        req_par_en   = 4'b0101;
        req_par_type = 4'b0011;
        req_valid    = 4'b1111;
        RST          = 1'b1;
        apply_stimulus("rh_first", 3'd0, 8'h10, 1'b1, 1'b1, 4'b0001);
        apply_stimulus("rh_second", 3'd1, 8'h11, 1'b0, 1'b1, 4'b0010);
        req_valid = 4'b0000;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
